uart_alu_if: RTL and testbench

Command/response sequencer between the UART receiver and transmitter of the UART-controlled ALU. It collects three received bytes in order: operand A, operand B, opcode. It holds them on registered outputs driving the combinational ALU, then hands the ALU result to the UART transmitter with a one-cycle start pulse. It waits for transmit completion before accepting the next command.

---
 rtl/uart_alu_if.sv | 84 ++++++++
 tb/tb_uart_alu_if.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_if.sv
// Command/response sequencer between UART RX/TX and the combinational ALU:
// gathers A, B, opcode bytes, launches the result to the transmitter, waits for completion.
//
// state   | meaning
// WAIT_A  | idle, next received byte is operand A
// WAIT_B  | operand A held, next byte is operand B
// WAIT_OP | operands held, next byte supplies the opcode
// SEND    | one cycle: capture alu_result into tx_data, raise tx_start
// WAIT_TX | transmission in flight, wait for tx_done_tick
module uart_alu_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_done_tick,
    input  logic [NB_DATA-1:0] rx_data,
    input  logic [NB_DATA-1:0] alu_result,
    input  logic               tx_done_tick,
    output logic [NB_DATA-1:0] alu_a,
    output logic [NB_DATA-1:0] alu_b,
    output logic [NB_OP-1:0]   alu_op,
    output logic [NB_DATA-1:0] tx_data,
    output logic               tx_start,
    output logic               overrun
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        SEND,
        WAIT_TX
    } state_t;

    state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT_A;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (rx_done_tick) begin
                        alu_a <= rx_data;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (rx_done_tick) begin
                        alu_b <= rx_data;
                        state <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (rx_done_tick) begin
                        alu_op <= rx_data[NB_OP-1:0];
                        state  <= SEND;
                    end
                end
                // alu_op settled one full cycle ago, so alu_result is valid here
                SEND: begin
                    tx_data  <= alu_result;
                    tx_start <= 1'b1;
                    state    <= WAIT_TX;
                    if (rx_done_tick) overrun <= 1'b1;
                end
                WAIT_TX: begin
                    if (tx_done_tick) state <= WAIT_A;
                    if (rx_done_tick) overrun <= 1'b1;
                end
                default: state <= WAIT_A;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_if.sv
// Bench for uart_alu_if: directed scenarios then random byte/done traffic,
// compared every cycle against a command-level reference model.
module tb_uart_alu_if;

    logic       clk;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic [7:0] alu_result;
    logic       tx_done_tick;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    uart_alu_if #(.NB_DATA(8), .NB_OP(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .alu_result   (alu_result),
        .tx_done_tick (tx_done_tick),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            default: return a ^ {2'b00, op};
        endcase
    endfunction

    assign alu_result = alu_ref(alu_a, alu_b, alu_op);

    // Reference model: bytes collected so far, whether a result is owed, whether TX is busy
    logic [7:0] m_a, m_b, m_tx;
    logic [5:0] m_op;
    logic       m_start, m_ovr;
    int         m_nbytes;
    bit         m_due, m_busy;

    task automatic model_reset();
        m_a = 0; m_b = 0; m_op = 0; m_tx = 0; m_start = 0; m_ovr = 0;
        m_nbytes = 0; m_due = 0; m_busy = 0;
    endtask

    task automatic model_edge(input logic rx, input logic [7:0] d, input logic txd);
        m_start = 0;
        if (m_due) begin
            m_tx    = alu_ref(m_a, m_b, m_op);
            m_start = 1;
            m_due   = 0;
            m_busy  = 1;
            if (rx) m_ovr = 1;
        end else if (m_busy) begin
            if (txd) m_busy = 0;
            if (rx) m_ovr = 1;
        end else if (rx) begin
            if (m_nbytes == 0) m_a = d;
            else if (m_nbytes == 1) m_b = d;
            else m_op = d[5:0];
            m_nbytes = m_nbytes + 1;
            if (m_nbytes == 3) begin
                m_nbytes = 0;
                m_due    = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_op", {2'b00, alu_op}, {2'b00, m_op});
        chk("tx_data", tx_data, m_tx);
        chk("tx_start", {7'd0, tx_start}, {7'd0, m_start});
        chk("overrun", {7'd0, overrun}, {7'd0, m_ovr});
    endtask

    // One clock: drive inputs at the falling edge, check after the next falling edge
    task automatic cycle(input logic rx, input logic [7:0] d, input logic txd);
        rx_done_tick = rx;
        rx_data      = d;
        tx_done_tick = txd;
        model_edge(rx, d, txd);
        @(negedge clk);
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        check_all();
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input int gap);
        cycle(1'b1, a, 1'b0);
        idle(gap);
        cycle(1'b1, b, 1'b0);
        idle(gap);
        cycle(1'b1, op, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        tx_done_tick = 1'b0;
        model_reset();
        do_reset();
        do_reset();

        // spurious done in WAIT_A
        cycle(1'b0, 8'h00, 1'b1);

        // basic add, with a spurious done while waiting for B
        cycle(1'b1, 8'h05, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        idle(2);
        cycle(1'b1, 8'h03, 1'b0);
        idle(1);
        cycle(1'b1, 8'h20, 1'b0);
        idle(4);
        chk("add_result", tx_data, 8'h08);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h05, 1'b0);

        // opcode masking: 0xE2 keeps only low six bits
        cycle(1'b1, 8'h03, 1'b0);
        cycle(1'b1, 8'hE2, 1'b0);
        idle(2);
        chk("mask_op", {2'b00, alu_op}, 8'h22);
        chk("sub_result", tx_data, 8'h02);
        idle(3);
        cycle(1'b0, 8'h00, 1'b1);

        // overrun during SEND and WAIT_TX, then a normal command with overrun sticky
        send_cmd(8'h40, 8'h0F, 8'h24, 0);
        cycle(1'b1, 8'h7F, 1'b0);
        idle(2);
        cycle(1'b1, 8'h7F, 1'b0);
        chk("ovr_set", {7'd0, overrun}, 8'h01);
        cycle(1'b0, 8'h00, 1'b1);
        send_cmd(8'h30, 8'h0C, 8'h26, 1);
        idle(3);
        chk("ovr_xor", tx_data, 8'h3C);
        cycle(1'b0, 8'h00, 1'b1);

        // reset mid-command discards partial operands
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        do_reset();
        send_cmd(8'h09, 8'h04, 8'h20, 2);
        idle(3);
        chk("rst_result", tx_data, 8'h0D);
        cycle(1'b0, 8'h00, 1'b1);

        // back-to-back ticks, done in the tx_start cycle
        send_cmd(8'h01, 8'h02, 8'h20, 0);
        idle(1);
        chk("b2b_start", {7'd0, tx_start}, 8'h01);
        chk("b2b_result", tx_data, 8'h03);
        cycle(1'b0, 8'h00, 1'b1);
        idle(3);

        // coincident rx and done in WAIT_TX
        send_cmd(8'hA5, 8'h5A, 8'h25, 0);
        idle(2);
        cycle(1'b1, 8'h55, 1'b1);
        cycle(1'b1, 8'h66, 1'b0);
        chk("coinc_next_a", alu_a, 8'h66);
        do_reset();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else cycle(($urandom_range(0, 2) == 0), 8'($urandom),
                       ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
